// File: rtl/lshift_load_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lshift_pkg
// Shared types and helpers for the rotating left-shift load controller.
//   state_t      : controller FSM states
//   LSHIFT_WIDTH : shifter data width
//   rotl()       : rotate-left of a LSHIFT_WIDTH word by an arbitrary amount
//                  (amount is reduced modulo the width)
// ---------------------------------------------------------------------------
package lshift_pkg;

  localparam int LSHIFT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ROT  = 3'd2,
    CAPT = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic logic [LSHIFT_WIDTH-1:0] rotl(
    input logic [LSHIFT_WIDTH-1:0] v,
    input int unsigned             amt
  );
    logic [2*LSHIFT_WIDTH-1:0] dbl;
    int unsigned               a;
    a   = amt % LSHIFT_WIDTH;
    // Shifting the doubled word left leaves the rotated word in the top half.
    dbl = {v, v} << a;
    return dbl[2*LSHIFT_WIDTH-1 -: LSHIFT_WIDTH];
  endfunction

endpackage

// File: rtl/lshift_load_ctrl_if.sv
// ---------------------------------------------------------------------------
// lshift_load_ctrl_if
// Bundles the input stream, shifter load port, shifter output and result
// stream of the load controller.
//   in_data/in_valid/in_ready    : input word stream
//   load_val/load_en             : to shifter (registered)
//   op_in                        : shifter output
//   out_data/out_valid/out_ready : result stream
//   busy                         : controller not idle
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both 1; once valid is raised the producer holds
// valid and data stable until that transfer; ready may be raised or dropped
// freely and never depends on valid.
// master = controller view, slave = environment view.
// ---------------------------------------------------------------------------
interface lshift_load_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] load_val;
  logic             load_en;
  logic [WIDTH-1:0] op_in;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    input  in_data, in_valid, op_in, out_ready,
    output in_ready, load_val, load_en, out_data, out_valid, busy
  );

  modport slave (
    output in_data, in_valid, op_in, out_ready,
    input  in_ready, load_val, load_en, out_data, out_valid, busy
  );
endinterface

// File: rtl/lshift_load_ctrl_hold_buf.sv
// ---------------------------------------------------------------------------
// lshift_hold_buf
// One-entry holding register for a single pending input word.
//   clk, rst     : clock, synchronous active-high reset
//   in_valid_i   : write a word (caller only writes when there is room,
//                  or when the entry is drained in the same cycle)
//   in_data_i    : word to write
//   out_ready_i  : drain the held word
//   out_valid_o  : entry holds a word
//   out_data_o   : held word
// A write and a drain in the same cycle leave the entry full with the new word.
// ---------------------------------------------------------------------------
module lshift_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o
);
  logic             full_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (in_valid_i) begin
      full_q <= 1'b1;
      data_q <= in_data_i;
    end else if (out_ready_i) begin
      full_q <= 1'b0;
    end
  end

  assign out_valid_o = full_q;
  assign out_data_o  = data_q;
endmodule

// File: rtl/lshift_load_ctrl.sv
// ---------------------------------------------------------------------------
// lshift_load_ctrl
// Upstream controller for the 8-bit rotating left-shift register. Accepts a
// word, pulses load_en for one cycle with load_val=word, lets the shifter
// rotate for ROT_CYCLES clocks, captures the shifter output and offers it on
// the result stream. One word is in the shifter at a time.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus          : lshift_load_ctrl_if.master (streams, shifter port, busy)
//   dbg_state_o  : current FSM state
// Parameters: WIDTH (data width), ROT_CYCLES (1..255 rotate clocks per word),
//   CNT_W (rotate counter width, must hold ROT_CYCLES-1).
// Build option: define LSHIFT_LOAD_CTRL_BUF_EN to add a one-entry input
// holding buffer so a further word can be accepted while one is in flight.
// ---------------------------------------------------------------------------
module lshift_load_ctrl
  import lshift_pkg::*;
#(
  parameter int WIDTH      = LSHIFT_WIDTH,
  parameter int ROT_CYCLES = 3,
  parameter int CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  lshift_load_ctrl_if.master  bus,
  output state_t              dbg_state_o
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] load_val_q, load_val_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             load_en_q;
  logic             out_valid_q;
  logic             in_ready;
  logic             acc;

`ifdef LSHIFT_LOAD_CTRL_BUF_EN
  logic             buf_full;
  logic [WIDTH-1:0] buf_data;
  logic             buf_wr;
  logic             buf_rd;
  logic             direct;

  assign in_ready = !buf_full || (state_q == IDLE);
  // An idle controller with nothing buffered loads the word straight away;
  // every other accepted word waits in the buffer.
  assign direct   = (state_q == IDLE) && !buf_full;
  assign buf_wr   = acc && !direct;

  lshift_hold_buf #(.WIDTH(WIDTH)) u_hold_buf (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (buf_wr),
    .in_data_i   (bus.in_data),
    .out_ready_i (buf_rd),
    .out_valid_o (buf_full),
    .out_data_o  (buf_data)
  );
`else
  assign in_ready = (state_q == IDLE);
`endif

  assign acc = bus.in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_val_d = load_val_q;
    out_data_d = out_data_q;
`ifdef LSHIFT_LOAD_CTRL_BUF_EN
    buf_rd     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef LSHIFT_LOAD_CTRL_BUF_EN
        if (buf_full) begin
          state_d    = LOAD;
          load_val_d = buf_data;
          buf_rd     = 1'b1;
        end else if (acc) begin
          state_d    = LOAD;
          load_val_d = bus.in_data;
        end
`else
        if (acc) begin
          state_d    = LOAD;
          load_val_d = bus.in_data;
        end
`endif
      end
      LOAD: state_d = ROT;
      ROT: begin
        // Counter is cleared on leaving ROT so the next word starts at 0.
        if (cnt_q == CNT_LAST) begin
          state_d = CAPT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPT: begin
        out_data_d = bus.op_in;
        state_d    = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
`ifdef LSHIFT_LOAD_CTRL_BUF_EN
          if (buf_full) begin
            state_d    = LOAD;
            load_val_d = buf_data;
            buf_rd     = 1'b1;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // load_en and out_valid are registered decodes of the next state so they
  // line up exactly with the LOAD and DONE cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      load_val_q  <= '0;
      load_en_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_val_q  <= load_val_d;
      load_en_q   <= (state_d == LOAD);
      out_data_q  <= out_data_d;
      out_valid_q <= (state_d == DONE);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.load_val  = load_val_q;
  assign bus.load_en   = load_en_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != IDLE);
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_lshift_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lshift_load_ctrl
// Two controller instances (ROT_CYCLES=3 and 8), each paired with a
// behavioural rotate-left shifter. A word-level model tracks how many words
// are inside the controller, the order of loads and results, and the
// expected cycle of each load pulse and first out_valid.
// ---------------------------------------------------------------------------
module tb_lshift_load_ctrl;
  import lshift_pkg::*;

  localparam int W = LSHIFT_WIDTH;
`ifdef LSHIFT_LOAD_CTRL_BUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- DUTs and shifter models ----------------
  lshift_load_ctrl_if #(.WIDTH(W)) bus3 ();
  lshift_load_ctrl_if #(.WIDTH(W)) bus8 ();
  state_t dbg3, dbg8;

  lshift_load_ctrl #(.WIDTH(W), .ROT_CYCLES(3), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.master), .dbg_state_o(dbg3)
  );
  lshift_load_ctrl #(.WIDTH(W), .ROT_CYCLES(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8.master), .dbg_state_o(dbg8)
  );

  logic [W-1:0] sh3 = '0;
  logic [W-1:0] sh8 = '0;
  always @(posedge clk) sh3 <= bus3.load_en ? bus3.load_val : rotl(sh3, 1);
  always @(posedge clk) sh8 <= bus8.load_en ? bus8.load_val : rotl(sh8, 1);
  assign bus3.op_in = sh3;
  assign bus8.op_in = sh8;

  // sel picks which instance the driver and checks talk to.
  logic         sel = 1'b0;
  logic         drv_valid = 1'b0;
  logic [W-1:0] drv_data = '0;
  logic         drv_ordy = 1'b0;
  int           rot;

  assign bus3.in_valid  = !sel && drv_valid;
  assign bus3.in_data   = drv_data;
  assign bus3.out_ready = !sel && drv_ordy;
  assign bus8.in_valid  = sel && drv_valid;
  assign bus8.in_data   = drv_data;
  assign bus8.out_ready = sel && drv_ordy;
  assign rot            = sel ? 8 : 3;

  logic         o_in_ready, o_load_en, o_out_valid, o_busy;
  logic [W-1:0] o_load_val, o_out_data;
  state_t       o_state;
  assign o_in_ready  = sel ? bus8.in_ready  : bus3.in_ready;
  assign o_load_en   = sel ? bus8.load_en   : bus3.load_en;
  assign o_load_val  = sel ? bus8.load_val  : bus3.load_val;
  assign o_out_valid = sel ? bus8.out_valid : bus3.out_valid;
  assign o_out_data  = sel ? bus8.out_data  : bus3.out_data;
  assign o_busy      = sel ? bus8.busy      : bus3.busy;
  assign o_state     = sel ? dbg8           : dbg3;

  // ---------------- scoreboard / model state ----------------
  int           n_vec = 0;
  int           n_err = 0;
  int           n_words;
  logic [W-1:0] load_q[$];
  logic [W-1:0] exp_q[$];
  int           exp_load_cyc;
  int           exp_valid_cyc;
  bit           prev_load_en;
  bit           valid_seen;
  bit           pend;
  logic [W-1:0] pend_data;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, rot %0d)", tag, act, exp, cyc, rot);
    end
  endtask

  task automatic model_clear();
    n_words       = 0;
    load_q.delete();
    exp_q.delete();
    exp_load_cyc  = -1;
    exp_valid_cyc = -1;
    prev_load_en  = 1'b0;
    valid_seen    = 1'b0;
    pend          = 1'b0;
  endtask

  task automatic check_reset();
    check_val("rst_state",     o_state,     IDLE);
    check_val("rst_load_en",   o_load_en,   0);
    check_val("rst_load_val",  o_load_val,  0);
    check_val("rst_out_valid", o_out_valid, 0);
    check_val("rst_out_data",  o_out_data,  0);
    check_val("rst_busy",      o_busy,      0);
    check_val("rst_in_ready",  o_in_ready,  1);
  endtask

  // Holds rst for n rising edges, checks the reset values, then releases.
  task automatic do_reset(input int n);
    rst       = 1'b1;
    drv_valid = 1'b0;
    drv_ordy  = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    model_clear();
  endtask

  // ---------------- driver ----------------
  task automatic offer(input logic [W-1:0] w);
    pend      = 1'b1;
    pend_data = w;
  endtask

  // One clock: check outputs against the model, drive, advance, update.
  task automatic step(input bit ordy);
    bit acc, dlv;
    int c;
    c = cyc;
    check_val("in_ready", o_in_ready, (n_words < CAP));
`ifndef LSHIFT_LOAD_CTRL_BUF_EN
    check_val("busy", o_busy, (n_words > 0));
`endif
    if (o_load_en) begin
      check_val("load_pulse", prev_load_en, 0);
      check_val("load_pending", (load_q.size() > 0), 1);
      if (load_q.size() > 0) check_val("load_val", o_load_val, load_q.pop_front());
      if (exp_load_cyc >= 0) begin
        check_val("load_cycle", c, exp_load_cyc);
        exp_load_cyc = -1;
      end
      exp_valid_cyc = c + rot + 2;
    end else if (exp_load_cyc == c) begin
      check_val("load_late", o_load_en, 1);
      exp_load_cyc = -1;
    end
    prev_load_en = o_load_en;

    if (o_out_valid) begin
      if (exp_q.size() == 0) begin
        check_val("valid_unexpected", o_out_valid, 0);
      end else begin
        if (!valid_seen) begin
          check_val("valid_cycle", c, exp_valid_cyc);
          valid_seen = 1'b1;
        end
        check_val("out_data", o_out_data, exp_q[0]);
      end
    end else if (valid_seen) begin
      check_val("valid_drop", o_out_valid, 1);
    end else if (exp_valid_cyc == c) begin
      check_val("valid_late", o_out_valid, 1);
    end

    drv_valid = pend;
    drv_data  = pend ? pend_data : W'($urandom);
    drv_ordy  = ordy;
    acc = pend && o_in_ready;
    dlv = o_out_valid && ordy;
    @(posedge clk);
    if (acc) begin
      load_q.push_back(pend_data);
      exp_q.push_back(rotl(pend_data, rot));
      if (n_words == 0) exp_load_cyc = c + 1;
      pend = 1'b0;
    end
    if (dlv) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      // A word already waiting behind the delivered one loads right away.
      if (n_words == 2) exp_load_cyc = c + 1;
      valid_seen    = 1'b0;
      exp_valid_cyc = -1;
    end
    n_words = n_words + int'(acc) - int'(dlv);
    if (n_words < 0) n_words = 0;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input logic [W-1:0] exp);
    for (int i = 0; i < 40 && !o_out_valid; i++) step(1'b0);
    check_val({tag, "_seen"}, o_out_valid, 1);
    check_val(tag, o_out_data, exp);
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      if (!pend && $urandom_range(0, 2) != 0) offer(W'($urandom));
      step($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (n_words > 0 || pend); i++) step(1'b1);
    check_val("drain", n_words, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    model_clear();
    do_reset(3);

    // Single word 0x81, ROT_CYCLES=3.
    offer(8'h81);
    step(1'b1);
    wait_valid("rot3_81", 8'h0C);

    // Stalled sink holds the result and blocks the next word.
    offer(8'h3C);
    for (int i = 0; i < 10; i++) step(1'b0);
    check_val("stall_hold", o_out_data, 8'h0C);
    step(1'b1);
    wait_valid("rot3_3c", 8'hE1);
    step(1'b1);

    // Reset while rotating abandons the word.
    offer(8'h5A);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    do_reset(1);
    for (int i = 0; i < 20; i++) step(1'b1);

`ifdef LSHIFT_LOAD_CTRL_BUF_EN
    // Second word buffered during ROT, loaded straight out of DONE.
    offer(8'h01);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    offer(8'h80);
    step(1'b1);
    check_val("buf_accept", pend, 0);
    wait_valid("buf_first", 8'h08);
    step(1'b1);
    wait_valid("buf_second", 8'h04);
    step(1'b1);
`endif

    run_random(300);
    drain();

    // ROT_CYCLES=8 instance: full wrap-around.
    sel = 1'b1;
    do_reset(3);
    offer(8'hA5);
    step(1'b1);
    wait_valid("rot8_a5", 8'hA5);
    step(1'b1);
    run_random(300);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
